// File: rtl/spell_mem_banked_if.sv
// Request/response bus of the banked spell memory: one select/data_ready handshake
// shared by the code and data banks, plus the controller state for observation.
interface spell_mem_banked_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  // Handshake: the master raises select with stable request fields and holds it
  // until data_ready is seen; data_out/error are valid while data_ready is high;
  // the master then drops select for at least one edge before the next request.
  logic                  select;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [1:0]            memory_type;
  logic                  write;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_ready;
  logic                  error;
  logic [1:0]            fsm_state;

  modport master (
    output select, addr, data_in, memory_type, write,
    input  data_out, data_ready, error, fsm_state
  );

  modport slave (
    input  select, addr, data_in, memory_type, write,
    output data_out, data_ready, error, fsm_state
  );
endinterface

// File: rtl/spell_mem_banked.sv
// Banked (code + data) latency-configurable memory for the spell core.
// Optional SPELL_MEM_CODE_WP_EN: reject stores to the code bank with error=1.
module spell_mem_banked #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 8,
   parameter int LATENCY        = 4,
   parameter int CLEAR_ON_RESET = 1
) (
   input logic               clock,
   input logic               reset,
   spell_mem_banked_if.slave bus
);

   localparam int         DEPTH         = 1 << ADDR_WIDTH;
   localparam logic [1:0] MEM_TYPE_DATA = 2'b00;
   localparam logic [1:0] MEM_TYPE_CODE = 2'b01;

`ifdef SPELL_MEM_CODE_WP_EN
   localparam bit CODE_WP = 1'b1;
`else
   localparam bit CODE_WP = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state, state_d;
   logic [7:0]            cnt, cnt_d;
   logic                  capture;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [1:0]            type_q;
   logic                  write_q;

   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  ready_q, ready_d;
   logic                  error_q, error_d;
   logic                  data_we, code_we;

   logic [DATA_WIDTH-1:0] data_bank [DEPTH];
   logic [DATA_WIDTH-1:0] code_bank [DEPTH];

   logic is_code, type_legal, reject;

   assign is_code    = (type_q == MEM_TYPE_CODE);
   assign type_legal = (type_q == MEM_TYPE_DATA) || is_code;
   assign reject     = !type_legal || (CODE_WP && is_code && write_q);

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         type_q     <= '0;
         write_q    <= 1'b0;
         data_out_q <= '0;
         ready_q    <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         data_out_q <= data_out_d;
         ready_q    <= ready_d;
         error_q    <= error_d;
         if (capture) begin
            addr_q  <= bus.addr;
            data_q  <= bus.data_in;
            type_q  <= bus.memory_type;
            write_q <= bus.write;
         end
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      capture = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.select) begin
               state_d = WAIT;
               cnt_d   = 8'(LATENCY - 1);
               capture = 1'b1;
            end
         end
         WAIT: begin
            if (!bus.select)     state_d = IDLE;
            else if (cnt == '0)  state_d = DONE;
            else                 cnt_d   = cnt - 8'd1;
         end
         DONE: begin
            if (!bus.select) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The access itself happens only on the WAIT->DONE edge, from captured fields.
   always_comb begin
      data_out_d = data_out_q;
      ready_d    = ready_q;
      error_d    = error_q;
      data_we    = 1'b0;
      code_we    = 1'b0;
      unique case (state)
         IDLE: ;
         WAIT: begin
            if (!bus.select) begin
               error_d = 1'b0;
            end else if (cnt == '0) begin
               ready_d    = 1'b1;
               error_d    = 1'b0;
               data_out_d = '0;
               if (reject)       error_d    = 1'b1;
               else if (write_q) begin
                  data_we = !is_code;
                  code_we = is_code;
               end
               else if (is_code) data_out_d = code_bank[addr_q];
               else              data_out_d = data_bank[addr_q];
            end
         end
         DONE: begin
            if (!bus.select) begin
               ready_d    = 1'b0;
               data_out_d = '0;
               error_d    = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Reset takes priority so a transaction interrupted by reset never commits.
   always_ff @(posedge clock) begin
      if (reset) begin
         if (CLEAR_ON_RESET != 0) begin
            for (int i = 0; i < DEPTH; i++) begin
               data_bank[i] <= '0;
               code_bank[i] <= '0;
            end
         end
      end else begin
         if (data_we) data_bank[addr_q] <= data_q;
         if (code_we) code_bank[addr_q] <= data_q;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_ready = ready_q;
   assign bus.error      = error_q;
   assign bus.fsm_state  = state;

endmodule

// File: tb/tb_spell_mem_banked.sv
// Bench for spell_mem_banked: default instance (8/8, latency 4) plus a wide
// instance (10/16, latency 1); table vectors, corner sequences, random vs model.
module tb_spell_mem_banked;

   localparam logic [1:0] MT_DATA = 2'b00;
   localparam logic [1:0] MT_CODE = 2'b01;
   localparam logic [1:0] MT_BAD2 = 2'b10;
   localparam logic [1:0] MT_BAD3 = 2'b11;
   localparam int         LAT_S   = 4;
   localparam int         LAT_B   = 1;

`ifdef SPELL_MEM_CODE_WP_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   logic clock;
   logic reset;
   int   tests;
   int   fails;

   spell_mem_banked_if #(.ADDR_WIDTH(8),  .DATA_WIDTH(8))  sif ();
   spell_mem_banked_if #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) bif ();

   spell_mem_banked #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(LAT_S), .CLEAR_ON_RESET(1))
      u_small (.clock(clock), .reset(reset), .bus(sif));
   spell_mem_banked #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .LATENCY(LAT_B), .CLEAR_ON_RESET(1))
      u_big (.clock(clock), .reset(reset), .bus(bif));

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // reference model of the default instance: two plain word arrays
   logic [7:0]  m_data [256];
   logic [7:0]  m_code [256];
   logic [16:0] exp_q [$];

   function automatic void model_clear();
      for (int i = 0; i < 256; i++) begin
         m_data[i] = 8'h00;
         m_code[i] = 8'h00;
      end
   endfunction

   function automatic void model(input logic [1:0] mt, input logic wr, input logic [7:0] a,
                                 input logic [7:0] d, output logic [7:0] dout, output logic err);
      bit legal;
      legal = (mt == MT_DATA) || (mt == MT_CODE);
      dout  = 8'h00;
      err   = 1'b0;
      if (!legal || (WP && mt == MT_CODE && wr)) err = 1'b1;
      else if (wr && mt == MT_CODE) m_code[a] = d;
      else if (wr)                  m_data[a] = d;
      else if (mt == MT_CODE)       dout = m_code[a];
      else                          dout = m_data[a];
   endfunction

   // driver tasks
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input bit big, input logic sel, input logic [1:0] mt, input logic wr,
                        input logic [9:0] a, input logic [15:0] d);
      if (big) begin
         bif.select = sel; bif.memory_type = mt; bif.write = wr;
         bif.addr = a; bif.data_in = d;
      end else begin
         sif.select = sel; sif.memory_type = mt; sif.write = wr;
         sif.addr = a[7:0]; sif.data_in = d[7:0];
      end
   endtask

   function automatic logic get_ready(input bit big);
      return big ? bif.data_ready : sif.data_ready;
   endfunction

   function automatic logic [15:0] get_dout(input bit big);
      return big ? bif.data_out : {8'h00, sif.data_out};
   endfunction

   function automatic logic get_err(input bit big);
      return big ? bif.error : sif.error;
   endfunction

   // Counts edges after the capture edge until data_ready is seen (bounded).
   task automatic wait_ready(input bit big, output int lat);
      lat = 0;
      do begin
         @(posedge clock); #1;
         lat++;
      end while (!get_ready(big) && lat < 300);
   endtask

   task automatic release_sel(input bit big);
      @(negedge clock);
      drive(big, 1'b0, MT_DATA, 1'b0, 10'h0, 16'h0);
      @(posedge clock); #1;
      check("ready_drop", {15'd0, get_ready(big), get_dout(big)}, 32'd0);
   endtask

   task automatic access(input bit big, input logic [1:0] mt, input logic wr, input logic [9:0] a,
                         input logic [15:0] d, output logic [15:0] dout, output logic err,
                         output int lat);
      @(negedge clock);
      drive(big, 1'b1, mt, wr, a, d);
      @(posedge clock);
      wait_ready(big, lat);
      dout = get_dout(big);
      err  = get_err(big);
      release_sel(big);
   endtask

   // scoreboard access on the default instance
   task automatic acc_chk(input string name, input logic [1:0] mt, input logic wr,
                          input logic [7:0] a, input logic [7:0] d);
      logic [7:0]  edout;
      logic        eerr;
      logic [16:0] exp;
      logic [15:0] dout;
      logic        err;
      int          lat;
      model(mt, wr, a, d, edout, eerr);
      exp_q.push_back({eerr, 8'h00, edout});
      access(1'b0, mt, wr, {2'b00, a}, {8'h00, d}, dout, err, lat);
      exp = exp_q.pop_front();
      check($sformatf("%s_dout", name), {16'd0, dout}, {16'd0, exp[15:0]});
      check($sformatf("%s_err", name), {31'd0, err}, {31'd0, exp[16]});
      check($sformatf("%s_lat", name), lat, LAT_S);
   endtask

   typedef struct {
      string      name;
      logic [1:0] mt;
      logic       wr;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] exp_dout;
      logic       exp_err;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [15:0] dout;
      logic        err;
      logic [7:0]  md;
      logic        me;
      int          lat;
      tests = 0;
      fails = 0;

      tbl[0]  = '{"ld_ff_reset",   MT_DATA, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0};
      tbl[1]  = '{"st_data_3c",    MT_DATA, 1'b1, 8'h3C, 8'hA5, 8'h00, 1'b0};
      tbl[2]  = '{"ld_data_3c",    MT_DATA, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0};
      tbl[3]  = '{"ld_code_3c",    MT_CODE, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b0};
      tbl[4]  = '{"st_bad3_3c",    MT_BAD3, 1'b1, 8'h3C, 8'h55, 8'h00, 1'b1};
      tbl[5]  = '{"ld_bad2_3c",    MT_BAD2, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b1};
      tbl[6]  = '{"ld_data_3c_b",  MT_DATA, 1'b0, 8'h3C, 8'h00, 8'hA5, 1'b0};
      tbl[7]  = '{"ld_code_3c_b",  MT_CODE, 1'b0, 8'h3C, 8'h00, 8'h00, 1'b0};
      tbl[8]  = '{"st_code_05",    MT_CODE, 1'b1, 8'h05, 8'h77, 8'h00, WP};
      tbl[9]  = '{"ld_code_05",    MT_CODE, 1'b0, 8'h05, 8'h00, WP ? 8'h00 : 8'h77, 1'b0};
      tbl[10] = '{"ld_data_05",    MT_DATA, 1'b0, 8'h05, 8'h00, 8'h00, 1'b0};
      tbl[11] = '{"st_data_ff",    MT_DATA, 1'b1, 8'hFF, 8'h81, 8'h00, 1'b0};

      reset = 1'b1;
      drive(1'b0, 1'b0, MT_DATA, 1'b0, 10'h0, 16'h0);
      drive(1'b1, 1'b0, MT_DATA, 1'b0, 10'h0, 16'h0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_clear();
      check("rst_ready",   {31'd0, sif.data_ready}, 32'd0);
      check("rst_err",     {31'd0, sif.error},      32'd0);
      check("rst_dout",    {24'd0, sif.data_out},   32'd0);
      check("rst_state",   {30'd0, sif.fsm_state},  32'd0);
      check("rst_b_ready", {31'd0, bif.data_ready}, 32'd0);
      check("rst_b_dout",  {16'd0, bif.data_out},   32'd0);

      // wide instance, latency 1
      access(1'b1, MT_DATA, 1'b0, 10'h3FF, 16'h0, dout, err, lat);
      check("big_ld3ff_lat", lat, LAT_B);
      check("big_ld3ff_dout", {16'd0, dout}, 32'd0);
      access(1'b1, MT_DATA, 1'b1, 10'h23C, 16'hA5A5, dout, err, lat);
      check("big_st_err", {31'd0, err}, 32'd0);
      check("big_st_lat", lat, LAT_B);
      access(1'b1, MT_DATA, 1'b0, 10'h23C, 16'h0, dout, err, lat);
      check("big_ld_dout", {16'd0, dout}, 32'h0000A5A5);
      access(1'b1, MT_CODE, 1'b0, 10'h23C, 16'h0, dout, err, lat);
      check("big_code_iso", {16'd0, dout}, 32'd0);
      access(1'b1, MT_DATA, 1'b0, 10'h03C, 16'h0, dout, err, lat);
      check("big_no_alias", {16'd0, dout}, 32'd0);

      // table vectors on the default instance
      for (int i = 0; i < 12; i++) begin
         model(tbl[i].mt, tbl[i].wr, tbl[i].a, tbl[i].d, md, me);
         access(1'b0, tbl[i].mt, tbl[i].wr, {2'b00, tbl[i].a}, {8'h00, tbl[i].d}, dout, err, lat);
         check($sformatf("%s_dout", tbl[i].name), {16'd0, dout}, {24'd0, tbl[i].exp_dout});
         check($sformatf("%s_err", tbl[i].name), {31'd0, err}, {31'd0, tbl[i].exp_err});
         check($sformatf("%s_lat", tbl[i].name), lat, LAT_S);
      end

      // request fields changed during WAIT must be ignored
      acc_chk("prep_10", MT_DATA, 1'b1, 8'h10, 8'h5A);
      acc_chk("prep_11", MT_DATA, 1'b1, 8'h11, 8'hC3);
      @(negedge clock);
      drive(1'b0, 1'b1, MT_DATA, 1'b0, 10'h010, 16'h0);
      @(posedge clock);
      @(negedge clock);
      drive(1'b0, 1'b1, MT_CODE, 1'b1, 10'h011, 16'h00EE);
      wait_ready(1'b0, lat);
      check("capt_lat", lat, LAT_S);
      check("capt_dout", {16'd0, get_dout(1'b0)}, 32'h5A);
      check("capt_err", {31'd0, get_err(1'b0)}, 32'd0);
      release_sel(1'b0);
      acc_chk("capt_ld11", MT_DATA, 1'b0, 8'h11, 8'h00);
      acc_chk("capt_code11", MT_CODE, 1'b0, 8'h11, 8'h00);

      // abort a store after two edges
      acc_chk("prep_20", MT_DATA, 1'b1, 8'h20, 8'h99);
      @(negedge clock);
      drive(1'b0, 1'b1, MT_DATA, 1'b1, 10'h020, 16'h0044);
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      drive(1'b0, 1'b0, MT_DATA, 1'b0, 10'h0, 16'h0);
      @(posedge clock); #1;
      check("abort_ready", {31'd0, get_ready(1'b0)}, 32'd0);
      check("abort_state", {30'd0, sif.fsm_state}, 32'd0);
      acc_chk("abort_ld20", MT_DATA, 1'b0, 8'h20, 8'h00);

      // reset mid-WAIT drops the store; the top word is cleared as well
      @(negedge clock);
      drive(1'b0, 1'b1, MT_DATA, 1'b1, 10'h021, 16'h0066);
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      drive(1'b0, 1'b0, MT_DATA, 1'b0, 10'h0, 16'h0);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_clear();
      check("rst2_ready", {31'd0, sif.data_ready}, 32'd0);
      check("rst2_state", {30'd0, sif.fsm_state}, 32'd0);
      acc_chk("rst2_ld21", MT_DATA, 1'b0, 8'h21, 8'h00);
      acc_chk("rst2_ldff", MT_DATA, 1'b0, 8'hFF, 8'h00);
      acc_chk("rst2_ld3c", MT_DATA, 1'b0, 8'h3C, 8'h00);

      // randomized traffic against the model
      for (int n = 0; n < 150; n++) begin
         int         r;
         logic [1:0] mt;
         logic [7:0] a;
         r  = $urandom_range(0, 9);
         mt = (r < 4) ? MT_DATA : (r < 8) ? MT_CODE : (r == 8) ? MT_BAD2 : MT_BAD3;
         a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
         acc_chk($sformatf("rnd%0d", n), mt, 1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
